// File: rtl/instr_fetch_unit_pkg.sv
// Shared processor definitions: instruction word layout and fetch FSM states.
// Imported by the fetch unit and by the control unit that decodes out_opcode.
package instr_fetch_unit_pkg;
  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_sync_fifo.sv
// Single-clock FIFO with a combinational head and a synchronous clear.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_data    = r_mem[r_rd];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + PTR_W'(1);
      if (w_do_pop)  r_rd <= r_rd + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_do_push) - (PTR_W+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues sequential imem reads, buffers in-order responses
// with their PCs, and flushes stale traffic after a branch/jump redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [5:0]  out_opcode,
  output logic [31:0] out_pc
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FIFO_W = 2 * INSTR_W;

  fetch_state_t      r_state;
  logic [31:0]       r_fetch_pc;
  logic [CNT_W-1:0]  r_outst;
  logic [31:0]       r_pcq [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_pcq_wr;
  logic [PTR_W-1:0]  r_pcq_rd;

  logic [CNT_W-1:0]  w_fifo_count;
  logic [FIFO_W-1:0] w_fifo_head;
  logic [CNT_W:0]    w_inflight;
  logic [CNT_W-1:0]  w_outst_nxt;
  logic              w_req_hs;
  logic              w_push;
  logic              w_pop;

  // Outstanding plus buffered never exceeds the FIFO, so every response has a slot.
  assign w_inflight     = {1'b0, r_outst} + {1'b0, w_fifo_count};
  assign imem_req_valid = rst_n && (r_state == ST_RUN) && !redirect_valid &&
                          (r_outst < CNT_W'(MAX_OUTST)) &&
                          (w_inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_addr      = r_fetch_pc;
  assign w_req_hs       = imem_req_valid && imem_req_ready;
  assign w_outst_nxt    = r_outst + CNT_W'(w_req_hs) - CNT_W'(imem_rsp_valid);

  assign w_push    = imem_rsp_valid && (r_state == ST_RUN) && !redirect_valid;
  assign out_valid = (w_fifo_count != '0) && (r_state == ST_RUN);
  assign w_pop     = out_valid && out_ready && !redirect_valid;

  assign out_instr  = w_fifo_head[FIFO_W-1:INSTR_W];
  assign out_pc     = w_fifo_head[INSTR_W-1:0];
  assign out_opcode = out_instr[OPC_MSB:OPC_LSB];

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (redirect_valid),
    .i_push  (w_push),
    .i_data  ({imem_rsp_data, r_pcq[r_pcq_rd]}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= RESET_PC;
      r_outst    <= '0;
      r_pcq_wr   <= '0;
      r_pcq_rd   <= '0;
    end else begin
      r_outst <= w_outst_nxt;
      if (w_req_hs)       r_pcq_wr <= r_pcq_wr + PTR_W'(1);
      if (imem_rsp_valid) r_pcq_rd <= r_pcq_rd + PTR_W'(1);
      if (redirect_valid)
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (w_req_hs)
        r_fetch_pc <= r_fetch_pc + 32'd4;
      // Stale responses are still popped from the pc queue while flushing.
      if (redirect_valid || (r_state == ST_FLUSH))
        r_state <= (w_outst_nxt != '0) ? ST_FLUSH : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_hs) r_pcq[r_pcq_wr] <= r_fetch_pc;
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: the bench acts as instruction memory and decode,
// with a scoreboard of expected {instr, pc} and an independent pop monitor.
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [31:0] out_pc;

  instr_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH),
    .MAX_OUTST  (MAXO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_opcode     (out_opcode),
    .out_pc         (out_pc)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  int          due_q[$];
  logic [31:0] m_next_pc;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          n_acc = 0;
  int          n_pop = 0;
  logic [31:0] last_pop_pc;
  bit          hs_flag;
  logic [31:0] hs_addr;
  bit          s_req_valid;
  bit          s_out_valid;
  logic [31:0] s_addr;
  bit          prev_stall = 0;
  bit          prev_redir = 0;
  logic [31:0] stall_addr;
  exp_t        mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:2], a[31:8] ^ 24'hA5C35A, 2'b01};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, req);
    end
  endtask

  // One clock: drive at negedge, sample and update the model 1ns later.
  task automatic cycle(input bit rdy, input bit rsp_en, input bit ordy,
                       input bit redir, input logic [31:0] rpc, input bit rstn);
    @(negedge clk);
    rst_n          = rstn;
    imem_req_ready = rdy;
    out_ready      = ordy;
    redirect_valid = rstn && redir;
    redirect_pc    = rpc;
    if (rstn && rsp_en && due_q.size() > 0 && due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0];
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_out_valid = out_valid;
    s_addr      = imem_addr;
    hs_flag     = imem_req_valid && imem_req_ready;
    hs_addr     = imem_addr;
    if (!rstn) begin
      exp_q.delete();
      mem_q.delete();
      due_q.delete();
      m_next_pc  = RST_PC;
      prev_stall = 0;
      prev_redir = 0;
      hs_flag    = 0;
    end else begin
      if (prev_redir) chk("post_redirect_out_valid", {31'd0, out_valid}, 32'd0);
      if (prev_stall && !redirect_valid) begin
        chk("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("req_hold_addr", imem_addr, stall_addr);
      end
      if (imem_rsp_valid) begin
        void'(mem_q.pop_front());
        void'(due_q.pop_front());
      end
      if (hs_flag) begin
        chk("fetch_addr", imem_addr, m_next_pc);
        exp_q.push_back('{instr: mem_word(imem_addr), pc: imem_addr});
        mem_q.push_back(mem_word(imem_addr));
        due_q.push_back(cyc + 1);
        m_next_pc = m_next_pc + 32'd4;
        n_acc++;
      end
      if (redirect_valid) begin
        exp_q.delete();
        m_next_pc = {rpc[31:2], 2'b00};
      end
      chk("outstanding_limit", {31'd0, mem_q.size() <= MAXO}, 32'd1);
      chk("buffer_limit", {31'd0, exp_q.size() <= DEPTH}, 32'd1);
      prev_stall = imem_req_valid && !imem_req_ready;
      stall_addr = imem_addr;
      prev_redir = redirect_valid;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && mem_q.size() == 0) break;
      cycle(0, 1, 1, 0, 32'd0, 1);
    end
    chk({nm, "_drained"}, exp_q.size() + mem_q.size(), 32'd0);
  endtask

  task automatic expect_first_pop(input string nm, input logic [31:0] pc);
    int  n0;
    bit  got;
    n0  = n_pop;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle(1, 1, 1, 0, 32'd0, 1);
      got = (n_pop != n0);
    end
    chk({nm, "_seen"}, {31'd0, got}, 32'd1);
    if (got) chk(nm, last_pop_pc, pc);
  endtask

  // Monitor: every accepted instruction is compared with the scoreboard head.
  always begin
    @(negedge clk);
    #2;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && redirect_valid === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", out_pc, 32'hDEAD_BEEF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_pc", out_pc, mon_e.pc);
        chk("out_instr", out_instr, mon_e.instr);
        chk("out_opcode", {26'd0, out_opcode}, {26'd0, mon_e.instr[31:26]});
        last_pop_pc = out_pc;
        n_pop++;
      end
    end
  end

  initial begin
    int  n0;
    bit  got;
    logic [31:0] a_exp [5];
    a_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    rst_n = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    m_next_pc = RST_PC;

    cycle(0, 0, 0, 0, 32'd0, 0);
    cycle(0, 0, 0, 0, 32'd0, 0);
    chk("rst_req_valid", {31'd0, s_req_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, s_out_valid}, 32'd0);
    chk("rst_addr", s_addr, RST_PC);

    // Back-to-back fetch across the address wrap.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 1, 0, 32'd0, 1);
      chk("b2b_req", {31'd0, hs_flag}, 32'd1);
      chk("b2b_addr", hs_addr, a_exp[i]);
    end
    drain("b2b");

    // Decode stalled: fetch fills the buffer and stops.
    n0 = n_acc;
    repeat (10) cycle(1, 1, 0, 0, 32'd0, 1);
    chk("bp_accepted", n_acc - n0, 32'd4);
    chk("bp_req_stopped", {31'd0, s_req_valid}, 32'd0);
    chk("bp_out_valid", {31'd0, s_out_valid}, 32'd1);
    chk("bp_buffered", exp_q.size(), 32'd4);
    drain("bp");

    // Redirect with two requests outstanding.
    cycle(1, 0, 1, 0, 32'd0, 1);
    cycle(1, 0, 1, 0, 32'd0, 1);
    chk("flush_pre_outst", mem_q.size(), 32'd2);
    cycle(0, 0, 1, 1, 32'h0000_0103, 1);
    cycle(0, 0, 1, 0, 32'd0, 1);
    chk("flush_no_req", {31'd0, s_req_valid}, 32'd0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(1, 1, 1, 0, 32'd0, 1);
      got = hs_flag;
    end
    chk("redir_req_seen", {31'd0, got}, 32'd1);
    chk("redir_addr", hs_addr, 32'h0000_0100);
    chk("flush_outst_at_req", mem_q.size(), 32'd1);
    expect_first_pop("redir_first_pop", 32'h0000_0100);
    drain("redir");

    // Redirect coincident with a response and a pop.
    cycle(1, 1, 0, 0, 32'd0, 1);
    cycle(1, 1, 0, 0, 32'd0, 1);
    cycle(0, 0, 0, 0, 32'd0, 1);
    chk("coinc_pre_exp", exp_q.size(), 32'd2);
    cycle(0, 1, 1, 1, 32'h0000_2000, 1);
    chk("coinc_rsp_and_pop", {31'd0, s_out_valid && imem_rsp_valid}, 32'd1);
    cycle(0, 0, 0, 0, 32'd0, 1);
    chk("coinc_run_req", {31'd0, s_req_valid}, 32'd1);
    chk("coinc_out_valid", {31'd0, s_out_valid}, 32'd0);
    expect_first_pop("coinc_first_pop", 32'h0000_2000);
    drain("coinc");

    // One-cycle reset with requests in flight and data buffered.
    cycle(1, 1, 0, 0, 32'd0, 1);
    cycle(1, 1, 0, 0, 32'd0, 1);
    cycle(1, 0, 0, 0, 32'd0, 1);
    chk("mrst_pre_outst", mem_q.size(), 32'd2);
    cycle(0, 0, 0, 0, 32'd0, 0);
    cycle(1, 1, 1, 0, 32'd0, 1);
    chk("mrst_out_valid", {31'd0, s_out_valid}, 32'd0);
    chk("mrst_req", {31'd0, hs_flag}, 32'd1);
    chk("mrst_addr", hs_addr, RST_PC);
    cycle(1, 1, 1, 0, 32'd0, 1);
    chk("mrst_req2", {31'd0, hs_flag}, 32'd1);
    chk("mrst_addr2", hs_addr, RST_PC + 32'd4);
    drain("mrst");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            $urandom_range(0, 29) == 0, $urandom, $urandom_range(0, 399) != 0);
    end
    drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the instruction buffer entries (power of two, 2..16).
REQ-003 SHALL have parameter MAX_OUTST, default 2, the maximum outstanding imem requests (1..FIFO_DEPTH).
REQ-004 SHALL have port clk  in  1  single clock, all state updated on rising edge.
REQ-005 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-007 SHALL have port imem_req_ready  in  1  memory accepts request.
REQ-008 SHALL have port imem_addr  out  32  word-aligned fetch address.
REQ-009 SHALL have port imem_rsp_valid  in  1  in-order read data valid, at least 1 cycle after acceptance.
REQ-010 SHALL have port imem_rsp_data  in  32  instruction word.
REQ-011 SHALL have port redirect_valid  in  1  branch/jump taken, one-cycle pulse.
REQ-012 SHALL have port redirect_pc  in  32  new fetch target.
REQ-013 SHALL have port out_valid  out  1  instruction available to decode.
REQ-014 SHALL have port out_ready  in  1  decode stage consumes instruction.
REQ-015 SHALL have port out_instr  out  32  instruction word at FIFO head.
REQ-016 SHALL have port out_opcode  out  6  out_instr[31:26], fed to the control unit opcode input.
REQ-017 SHALL have port out_pc  out  32  address of out_instr.

Function
REQ-018 SHALL have two states: RUN (issue fetches) and FLUSH (discard stale responses, no requests).
REQ-019 SHALL, in RUN, assert imem_req_valid iff outstanding < MAX_OUTST and outstanding + fifo_count < FIFO_DEPTH and redirect_valid = 0.
REQ-020 SHALL hold imem_addr and imem_req_valid stable while imem_req_valid=1 and imem_req_ready=0.
REQ-021 SHALL, on request handshake, increment outstanding and advance fetch_pc by 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-022 SHALL, on imem_rsp_valid in RUN, push {rsp_data, pc of oldest outstanding} into the FIFO and decrement outstanding, same cycle.
REQ-023 SHALL present FIFO head combinationally on out_*; out_valid = (fifo_count != 0) and state = RUN.
REQ-024 SHALL pop the head when out_valid and out_ready; simultaneous push and pop leaves fifo_count unchanged, including when full.
REQ-025 SHALL, on redirect_valid: clear FIFO, load fetch_pc = {redirect_pc[31:2], 2'b00}, and go to FLUSH if outstanding (after this cycle's response) > 0, else stay RUN.
REQ-026 SHALL, in FLUSH, drop every response, decrement outstanding, and return to RUN the cycle after outstanding reaches 0.
REQ-027 SHALL drop a response arriving in the same cycle as redirect_valid.
REQ-028 SHALL let a redirect during FLUSH only update fetch_pc.
REQ-029 SHALL not pop the FIFO in a redirect cycle; out_valid is 0 the cycle after redirect.
REQ-030 SHALL never overflow the FIFO; total latency request-accept to out_valid is rsp latency + 1 registered cycle maximum 0 extra (push visible next cycle).

Reset
REQ-031 SHALL, when rst_n=0 at a clock edge, set state=RUN, fetch_pc=RESET_PC, outstanding=0, fifo_count=0, imem_req_valid=0, out_valid=0.
REQ-032 SHALL treat reset mid-transaction as abandoning in-flight requests; the memory model is reset concurrently.
REQ-033 SHALL issue its first request no earlier than the first edge with rst_n=1.

Structure
REQ-034 SHALL place opcode field bounds (31:26), instruction width 32 and the state enum in the shared processor package used by the control unit.
REQ-035 SHALL instantiate one sub-module, sync_fifo, parameterised by width (64) and depth; outstanding PCs tracked by a small pc queue inside instr_fetch_unit.

Verification
REQ-036 SHALL cover: reset, req_ready=1, 1-cycle rsp -> addrs 0x0,0x4,0x8 issued back-to-back; out_pc 0x0,0x4,0x8 with matching out_opcode.
REQ-037 SHALL cover: out_ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 instructions accepted, requests stop, no data lost on release.
REQ-038 SHALL cover: redirect_pc=0x103 with 2 outstanding -> FLUSH, 2 responses dropped, next request addr 0x100, first out_pc 0x100.
REQ-039 SHALL cover: redirect coincident with response and pop -> response dropped, FIFO empty, out_valid=0 next cycle.
REQ-040 SHALL cover: RESET_PC=0xFFFF_FFF8 -> fetch addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-041 SHALL cover: rst_n low for one cycle with 2 outstanding -> all outputs at reset values, fetch restarts at RESET_PC.
